// File: rtl/fanout_fork_fifo_pkg.sv
// rtl/fanout_fork_fifo_pkg.sv - shared constants and types for the fanout fork FIFO
// Purpose: default payload width and branch count, FIFO depth and the
//          occupancy count type used by fanout_fork_fifo.
package fanout_fork_fifo_pkg;
  localparam int DEF_WIDTH   = 17;  // 16 data bits plus 1 control bit
  localparam int DEF_NUM_OUT = 9;   // fanout branches, legal 1..16
  localparam int FIFO_DEPTH  = 2;

  typedef logic [1:0] count_t;      // occupancy 0..2
endpackage

// File: rtl/fanout_done_reduce.sv
// rtl/fanout_done_reduce.sv - combinational merge of per-branch completion
// Purpose: a branch is satisfied when disabled, already accepted, or
//          accepting this cycle; all_done is the AND across branches.
// Ports:
//   en       - per-branch enable
//   done     - per-branch accepted-this-entry flags
//   ready    - per-branch downstream ready
//   all_done - every branch satisfied, head may pop
module fanout_done_reduce #(
  parameter int N = 9
) (
  input  logic [N-1:0] en,
  input  logic [N-1:0] done,
  input  logic [N-1:0] ready,
  output logic         all_done
);
  assign all_done = &(~en | done | ready);
endmodule

// File: rtl/fanout_fork_fifo.sv
// rtl/fanout_fork_fifo.sv - 2-entry FIFO whose head is broadcast to N branches
// Purpose: buffers upstream payloads and holds the head until every enabled
//          branch has accepted it once, then pops.
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   clk_en              - global enable; low holds all state, gates valid/ready
//   flush               - synchronous clear of contents and accept state
//   in_data/valid/ready - upstream handshake
//   branch_en           - per-branch enable
//   out_data            - head entry shared by all branches
//   out_valid/out_ready - per-branch handshake
//   all_done            - all branches satisfied for the head
module fanout_fork_fifo
  import fanout_fork_fifo_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int NUM_OUT = DEF_NUM_OUT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clk_en,
  input  logic               flush,
  input  logic [WIDTH-1:0]   in_data,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [NUM_OUT-1:0] branch_en,
  output logic [WIDTH-1:0]   out_data,
  output logic [NUM_OUT-1:0] out_valid,
  input  logic [NUM_OUT-1:0] out_ready,
  output logic               all_done
);
  logic [WIDTH-1:0]   r_mem [FIFO_DEPTH];
  logic               r_wr_ptr;
  logic               r_rd_ptr;
  count_t             r_count;
  logic [NUM_OUT-1:0] r_done;

  logic               w_not_empty;
  logic               w_push;
  logic               w_pop;
  logic [NUM_OUT-1:0] w_accept;
  logic               w_all_done;

  fanout_done_reduce #(.N(NUM_OUT)) u_done_reduce (
    .en       (branch_en),
    .done     (r_done),
    .ready    (out_ready),
    .all_done (w_all_done)
  );

  assign w_not_empty = (r_count != count_t'(0));
  // Depends only on occupancy, so out_ready never reaches in_ready.
  assign in_ready    = clk_en & (r_count != count_t'(FIFO_DEPTH));
  assign w_push      = in_valid & in_ready;
  assign w_pop       = clk_en & w_not_empty & w_all_done;
  assign out_data    = r_mem[r_rd_ptr];
  assign out_valid   = {NUM_OUT{clk_en & w_not_empty}} & branch_en & ~r_done;
  assign w_accept    = out_valid & out_ready;
  assign all_done    = w_all_done;

  // Payload storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (w_push && !flush) begin
      r_mem[r_wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= count_t'(0);
      r_done   <= '0;
    end else if (clk_en) begin
      if (flush) begin
        r_wr_ptr <= 1'b0;
        r_rd_ptr <= 1'b0;
        r_count  <= count_t'(0);
        r_done   <= '0;
      end else begin
        if (w_push) r_wr_ptr <= ~r_wr_ptr;
        if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + count_t'(1);
          2'b01:   r_count <= r_count - count_t'(1);
          default: r_count <= r_count;
        endcase
        // A pop starts a fresh entry, so accept history is discarded.
        r_done <= w_pop ? '0 : (r_done | w_accept);
      end
    end
  end
endmodule

// File: tb/tb_fanout_fork_fifo.sv
// tb/tb_fanout_fork_fifo.sv - scoreboard testbench for fanout_fork_fifo
module tb_fanout_fork_fifo;
  localparam int W = 17;
  localparam int N = 9;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         clk_en;
  logic         flush;
  logic [W-1:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] branch_en;
  logic [W-1:0] out_data;
  logic [N-1:0] out_valid;
  logic [N-1:0] out_ready;
  logic         all_done;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] exp_q[$];
  logic [N-1:0] head_mask = '0;

  fanout_fork_fifo #(.WIDTH(W), .NUM_OUT(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clk_en    (clk_en),
    .flush     (flush),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .branch_en (branch_en),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .all_done  (all_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  // Monitor: samples mid-cycle, checks deliveries against the expected queue.
  always @(negedge clk) begin
    logic [N-1:0] acc;
    if (!rst_n) begin
      exp_q.delete();
      head_mask = '0;
    end else if (clk_en && flush) begin
      exp_q.delete();
      head_mask = '0;
    end else begin
      chk("mon_in_ready", {31'd0, in_ready}, {31'd0, (clk_en && exp_q.size() < 2)});
      if (!clk_en || exp_q.size() == 0)
        chk("mon_valid_idle", {23'd0, out_valid}, 32'd0);
      chk("mon_valid_en", {23'd0, out_valid & ~branch_en}, 32'd0);
      acc = out_valid & out_ready;
      if (acc != '0) begin
        if (exp_q.size() == 0) chk("mon_unexpected_out", 32'd1, 32'd0);
        else                   chk("mon_data", {15'd0, out_data}, {15'd0, exp_q[0]});
        chk("mon_dup", {23'd0, acc & head_mask}, 32'd0);
        head_mask = head_mask | acc;
      end
      if (clk_en && exp_q.size() != 0 && all_done) begin
        void'(exp_q.pop_front());
        head_mask = '0;
      end
      if (in_valid && in_ready) exp_q.push_back(in_data);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; clk_en = 1'b1; flush = 1'b0;
    in_data = '0; in_valid = 1'b0;
    branch_en = 9'h1FF; out_ready = 9'h1FF;
    neg();
    chk("rst_out_valid", {23'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_all_done", {31'd0, all_done}, 32'd1);
    step(); rst_n = 1'b1;

    // Single broadcast to all nine branches
    step(); in_data = 17'h1ABCD; in_valid = 1'b1;
    neg(); chk("t1_in_ready", {31'd0, in_ready}, 32'd1);
    step(); in_valid = 1'b0;
    neg();
    chk("t1_out_valid", {23'd0, out_valid}, 32'h1FF);
    chk("t1_out_data", {15'd0, out_data}, 32'h1ABCD);
    chk("t1_in_ready2", {31'd0, in_ready}, 32'd1);
    step(); neg();
    chk("t1_popped", {23'd0, out_valid}, 32'd0);

    // Staggered accepts on three branches
    branch_en = 9'h007; out_ready = 9'h000;
    step(); in_data = 17'h00111; in_valid = 1'b1;
    step(); in_valid = 1'b0; out_ready = 9'h001;
    neg();
    chk("t2_v0", {23'd0, out_valid}, 32'h007);
    chk("t2_ad0", {31'd0, all_done}, 32'd0);
    step(); out_ready = 9'h002;
    neg(); chk("t2_v1", {23'd0, out_valid}, 32'h006);
    step(); out_ready = 9'h004;
    neg();
    chk("t2_v2", {23'd0, out_valid}, 32'h004);
    chk("t2_ad2", {31'd0, all_done}, 32'd1);
    step(); out_ready = 9'h000;
    neg(); chk("t2_popped", {23'd0, out_valid}, 32'd0);

    // Fill to two with outputs stalled, then drain in order
    branch_en = 9'h1FF;
    step(); in_data = 17'h0000A; in_valid = 1'b1;
    neg(); chk("t3_rdy_a", {31'd0, in_ready}, 32'd1);
    step(); in_data = 17'h0000B;
    neg(); chk("t3_rdy_b", {31'd0, in_ready}, 32'd1);
    step(); in_data = 17'h0000C;
    neg(); chk("t3_full", {31'd0, in_ready}, 32'd0);
    step();
    neg(); chk("t3_full_hold", {31'd0, in_ready}, 32'd0);
    step(); out_ready = 9'h1FF;
    neg();
    chk("t3_no_comb_path", {31'd0, in_ready}, 32'd0);
    chk("t3_head_a", {15'd0, out_data}, 32'h0000A);
    step();
    neg();
    chk("t3_rdy_after_pop", {31'd0, in_ready}, 32'd1);
    chk("t3_head_b", {15'd0, out_data}, 32'h0000B);
    step(); in_valid = 1'b0;
    neg(); chk("t3_head_c", {15'd0, out_data}, 32'h0000C);
    step();
    neg(); chk("t3_empty", {23'd0, out_valid}, 32'd0);

    // No branch enabled: entries are dropped
    branch_en = 9'h000; out_ready = 9'h000;
    step(); in_data = 17'h0000D; in_valid = 1'b1;
    step(); in_data = 17'h0000E;
    neg();
    chk("t4_v_d", {23'd0, out_valid}, 32'd0);
    chk("t4_ad", {31'd0, all_done}, 32'd1);
    step(); in_valid = 1'b0;
    neg(); chk("t4_v_e", {23'd0, out_valid}, 32'd0);
    step();
    neg(); chk("t4_drained", {31'd0, in_ready}, 32'd1);

    // Disabling the last pending branch releases the head
    branch_en = 9'h003;
    step(); in_data = 17'h0000F; in_valid = 1'b1;
    step(); in_valid = 1'b0; out_ready = 9'h001;
    neg(); chk("t5_v0", {23'd0, out_valid}, 32'h003);
    step(); out_ready = 9'h000;
    neg();
    chk("t5_v1", {23'd0, out_valid}, 32'h002);
    chk("t5_ad1", {31'd0, all_done}, 32'd0);
    step(); branch_en = 9'h001;
    neg();
    chk("t5_v2", {23'd0, out_valid}, 32'd0);
    chk("t5_ad2", {31'd0, all_done}, 32'd1);
    step(); branch_en = 9'h003; in_data = 17'h00010; in_valid = 1'b1;
    step(); in_valid = 1'b0;
    neg(); chk("t5_done_cleared", {23'd0, out_valid}, 32'h003);
    step(); out_ready = 9'h003;
    step(); out_ready = 9'h000;
    neg(); chk("t5_delivered", {23'd0, out_valid}, 32'd0);

    // Flush with two entries and partial accept
    step(); in_data = 17'h00020; in_valid = 1'b1;
    step(); in_data = 17'h00021;
    step(); in_valid = 1'b0; out_ready = 9'h002;
    neg(); chk("t6_v0", {23'd0, out_valid}, 32'h003);
    step(); out_ready = 9'h000;
    neg();
    chk("t6_v1", {23'd0, out_valid}, 32'h001);
    chk("t6_full", {31'd0, in_ready}, 32'd0);
    step(); flush = 1'b1;
    step(); flush = 1'b0;
    neg();
    chk("t6_flush_valid", {23'd0, out_valid}, 32'd0);
    chk("t6_flush_ready", {31'd0, in_ready}, 32'd1);
    chk("t6_flush_ad", {31'd0, all_done}, 32'd0);
    step(); in_data = 17'h00022; in_valid = 1'b1;
    step(); in_valid = 1'b0;
    neg(); chk("t6_post_flush", {23'd0, out_valid}, 32'h003);
    step(); out_ready = 9'h003;
    step(); out_ready = 9'h000;

    // Asynchronous reset with two entries and partial accept
    step(); in_data = 17'h00030; in_valid = 1'b1;
    step(); in_data = 17'h00031;
    step(); in_valid = 1'b0; out_ready = 9'h002;
    step(); out_ready = 9'h000;
    neg(); chk("t7_pre", {23'd0, out_valid}, 32'h001);
    step(); rst_n = 1'b0;
    #1;
    chk("t7_rst_valid", {23'd0, out_valid}, 32'd0);
    chk("t7_rst_ready", {31'd0, in_ready}, 32'd1);
    step(); rst_n = 1'b1;
    step(); in_data = 17'h00032; in_valid = 1'b1;
    step(); in_valid = 1'b0;
    neg(); chk("t7_post_rst", {23'd0, out_valid}, 32'h003);
    step(); out_ready = 9'h003;
    step(); out_ready = 9'h000;

    // clk_en low gates handshakes and holds state
    step(); in_data = 17'h00040; in_valid = 1'b1;
    step(); clk_en = 1'b0; in_data = 17'h00041;
    neg();
    chk("t8_gated_valid", {23'd0, out_valid}, 32'd0);
    chk("t8_gated_ready", {31'd0, in_ready}, 32'd0);
    step(); in_valid = 1'b0; out_ready = 9'h003;
    step(); clk_en = 1'b1; out_ready = 9'h000;
    neg();
    chk("t8_held_valid", {23'd0, out_valid}, 32'h003);
    chk("t8_held_data", {15'd0, out_data}, 32'h00040);
    step(); out_ready = 9'h003;
    step(); out_ready = 9'h000;
    neg();
    chk("t8_done", {23'd0, out_valid}, 32'd0);
    chk("sb_empty", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
